spi_slave_fpga_dev: RTL and testbench

SPI mode-0 slave that sits directly downstream of the FPGA SPI master on the vaux pins: it consumes mosi/ss/sck and drives miso back. All SPI inputs are oversampled in the system clock domain, so no logic is clocked by sck. It deserialises 12-bit command frames from the master and returns an 8-bit response word. A local client loads the response word and receives each completed command.

---
 rtl/spi_slave_fpga_dev.sv | 164 ++++++++++++++++
 tb/tb_spi_slave_fpga_dev.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_fpga_dev.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_fpga_dev
// Description : SPI mode-0 slave, fully oversampled in the clk domain.
//               Receives RX_WIDTH-bit commands and returns a TX_WIDTH-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_fpga_dev #(
  parameter int RX_WIDTH    = 12,
  parameter int TX_WIDTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                ss,
  input  logic                mosi,
  output logic                miso,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_load,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int            CW        = $clog2(RX_WIDTH + 1);
  localparam logic [CW-1:0] C_RX_FULL = CW'(RX_WIDTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q, fill_q;
  logic                   sck_prev_q, ss_prev_q, armed_q;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RX_WIDTH-1:0]    rx_shift_q, rx_shift_d;
  logic [TX_WIDTH-1:0]    tx_shift_q, tx_shift_d;
  logic [TX_WIDTH-1:0]    hold_q, hold_d;
  logic [RX_WIDTH-1:0]    rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   done_q, done_d;

  logic w_sck_s, w_ss_s, w_mosi_s;
  logic w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;

  assign w_sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign w_ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign w_mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign w_sck_rise = w_sck_s & ~sck_prev_q;
  assign w_sck_fall = ~w_sck_s & sck_prev_q;
  // Falling ss only counts once a genuine (non-preset) high sample was seen.
  assign w_ss_fall  = armed_q & ss_prev_q & ~w_ss_s;
  assign w_ss_rise  = w_ss_s & ~ss_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q  <= w_sck_s;
      ss_prev_q   <= w_ss_s;
      armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & w_ss_s);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    done_d      = done_q;

    if (tx_load) begin
      hold_d = tx_data;
    end

    // Delivery runs independently of state so a frame start in the same
    // cycle does not swallow the pending result.
    if (cnt_q == C_RX_FULL && !done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      done_d     = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (w_ss_fall) begin
          state_d    = ACTIVE;
          tx_shift_d = tx_load ? tx_data : hold_q;
          cnt_d      = '0;
          done_d     = 1'b0;
        end
      end
      ACTIVE: begin
        if (w_ss_rise) begin
          state_d = IDLE;
          if (cnt_q != '0 && cnt_q < C_RX_FULL) begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (w_sck_rise && cnt_q < C_RX_FULL) begin
            rx_shift_d = {rx_shift_q[RX_WIDTH-2:0], w_mosi_s};
            cnt_d      = cnt_q + CW'(1);
          end
          if (w_sck_fall) begin
            tx_shift_d = {tx_shift_q[TX_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == ACTIVE);
  assign miso      = (state_q == ACTIVE) & tx_shift_q[TX_WIDTH-1];
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_fpga_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_fpga_dev
// Description : Self-checking bench for spi_slave_fpga_dev with an rx scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_fpga_dev;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_load = 1'b0;
  logic [11:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rxv_cnt = 0;
  int err_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_rx = 12'h000;

  spi_slave_fpga_dev #(.RX_WIDTH(12), .TX_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every rx_valid cycle pops one expected frame.
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (rx_valid) begin
      logic [11:0] e;
      rxv_cnt++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_unexpected: got rx_data=%h with no frame expected", rx_data);
      end else begin
        e = exp_q.pop_front();
        if (rx_data !== e) $display("FAIL rx_data: got %h expected %h", rx_data, e);
        else pass_cnt++;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  // Mode-0 master at sck = clk/8; miso sampled just before each rising sck.
  task automatic spi_frame(input logic [15:0] data, input int nbits, input int load_at,
                           input logic [7:0] load_val, input bit end_frame,
                           output logic [11:0] miso_w);
    miso_w = 12'h000;
    ss = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      if (i == load_at) begin
        load_tx(load_val);
        wait_clk(3);
      end else begin
        wait_clk(4);
      end
      if (i < 12) miso_w[11-i] = miso;
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
    wait_clk(4);
    if (end_frame) begin
      ss = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    wait_clk(3);
    total_cnt += 5;
    if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso); else pass_cnt++;
    if (rx_data !== 12'h000) $display("FAIL reset_rx_data: got %h expected 000", rx_data); else pass_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else pass_cnt++;
    if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    rst = 1'b1;
    wait_clk(6);
  endtask

  task automatic test_reset_ss_low;
    int v0;
    v0 = rxv_cnt;
    ss = 1'b0;
    rst = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(10);
    for (int i = 0; i < 12; i++) begin
      sck = 1'b1; wait_clk(4);
      sck = 1'b0; wait_clk(4);
    end
    total_cnt += 2;
    if (busy !== 1'b0) $display("FAIL ss_low_busy: got %b expected 0", busy); else pass_cnt++;
    if (rxv_cnt !== v0) $display("FAIL ss_low_rx_valid: got %0d pulses expected 0", rxv_cnt - v0); else pass_cnt++;
    ss = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_basic;
    logic [11:0] m;
    int v0;
    v0 = rxv_cnt;
    load_tx(8'hA5);
    exp_q.push_back(12'hB55);
    spi_frame({4'h0, 12'hB55}, 12, -1, 8'h00, 1'b1, m);
    last_rx = 12'hB55;
    total_cnt += 2;
    if (m !== 12'hA50) $display("FAIL basic_miso: got %h expected a50", m); else pass_cnt++;
    if (rxv_cnt - v0 !== 1) $display("FAIL basic_pulses: got %0d expected 1", rxv_cnt - v0); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [11:0] m1, m2;
    int v0;
    v0 = rxv_cnt;
    exp_q.push_back(12'h123);
    spi_frame({4'h0, 12'h123}, 12, -1, 8'h00, 1'b1, m1);
    exp_q.push_back(12'hFED);
    spi_frame({4'h0, 12'hFED}, 12, -1, 8'h00, 1'b1, m2);
    last_rx = 12'hFED;
    total_cnt += 3;
    if (m1 !== 12'hA50) $display("FAIL b2b_miso1: got %h expected a50", m1); else pass_cnt++;
    if (m2 !== 12'hA50) $display("FAIL b2b_miso2: got %h expected a50", m2); else pass_cnt++;
    if (rxv_cnt - v0 !== 2) $display("FAIL b2b_pulses: got %0d expected 2", rxv_cnt - v0); else pass_cnt++;
  endtask

  task automatic test_midframe_load;
    logic [11:0] m1, m2;
    exp_q.push_back(12'h5A5);
    spi_frame({4'h0, 12'h5A5}, 12, 4, 8'h3C, 1'b1, m1);
    exp_q.push_back(12'h3C3);
    spi_frame({4'h0, 12'h3C3}, 12, -1, 8'h00, 1'b1, m2);
    last_rx = 12'h3C3;
    total_cnt += 2;
    if (m1 !== 12'hA50) $display("FAIL midload_cur_miso: got %h expected a50", m1); else pass_cnt++;
    if (m2 !== 12'h3C0) $display("FAIL midload_next_miso: got %h expected 3c0", m2); else pass_cnt++;
  endtask

  task automatic test_short_frame;
    logic [11:0] m;
    int v0, e0;
    v0 = rxv_cnt;
    e0 = err_cnt;
    spi_frame({9'h0, 7'h55}, 7, -1, 8'h00, 1'b1, m);
    total_cnt += 4;
    if (err_cnt - e0 !== 1) $display("FAIL short_frame_err: got %0d pulses expected 1", err_cnt - e0); else pass_cnt++;
    if (rxv_cnt !== v0) $display("FAIL short_rx_valid: got %0d pulses expected 0", rxv_cnt - v0); else pass_cnt++;
    if (rx_data !== last_rx) $display("FAIL short_rx_data: got %h expected %h", rx_data, last_rx); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL short_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_overlong;
    logic [11:0] m;
    int v0, e0;
    v0 = rxv_cnt;
    e0 = err_cnt;
    exp_q.push_back(12'hABC);
    spi_frame({2'b00, 12'hABC, 2'b11}, 14, -1, 8'h00, 1'b1, m);
    last_rx = 12'hABC;
    total_cnt += 4;
    if (m !== 12'h3C0) $display("FAIL long_miso: got %h expected 3c0", m); else pass_cnt++;
    if (rxv_cnt - v0 !== 1) $display("FAIL long_pulses: got %0d expected 1", rxv_cnt - v0); else pass_cnt++;
    if (err_cnt !== e0) $display("FAIL long_frame_err: got %0d pulses expected 0", err_cnt - e0); else pass_cnt++;
    if (rx_data !== 12'hABC) $display("FAIL long_rx_data: got %h expected abc", rx_data); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    logic [11:0] m;
    int v0, e0;
    v0 = rxv_cnt;
    e0 = err_cnt;
    spi_frame({10'h0, 6'h2B}, 6, -1, 8'h00, 1'b0, m);
    rst = 1'b0;
    wait_clk(2);
    total_cnt += 5;
    if (miso !== 1'b0) $display("FAIL rstmid_miso: got %b expected 0", miso); else pass_cnt++;
    if (rx_data !== 12'h000) $display("FAIL rstmid_rx_data: got %h expected 000", rx_data); else pass_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid); else pass_cnt++;
    if (frame_err !== 1'b0) $display("FAIL rstmid_frame_err: got %b expected 0", frame_err); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else pass_cnt++;
    rst = 1'b1;
    wait_clk(4);
    ss = 1'b1;
    wait_clk(8);
    total_cnt += 2;
    if (rxv_cnt !== v0) $display("FAIL rstmid_no_valid: got %0d pulses expected 0", rxv_cnt - v0); else pass_cnt++;
    if (err_cnt !== e0) $display("FAIL rstmid_no_err: got %0d pulses expected 0", err_cnt - e0); else pass_cnt++;
    exp_q.push_back(12'h0F0);
    spi_frame({4'h0, 12'h0F0}, 12, -1, 8'h00, 1'b1, m);
    total_cnt += 2;
    if (m !== 12'h000) $display("FAIL rstmid_miso_cleared: got %h expected 000", m); else pass_cnt++;
    if (rx_data !== 12'h0F0) $display("FAIL rstmid_rx_after: got %h expected 0f0", rx_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_reset_ss_low();
    test_basic();
    test_back_to_back();
    test_midframe_load();
    test_short_frame();
    test_overlong();
    test_reset_midframe();
    wait_clk(10);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d frames never delivered", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
